// File: rtl/lsu_dbus_master_pkg.sv
// lsu_dbus_master_pkg: funct3 codes, FSM states, byte-enable width and access-size decode
// shared by the load/store unit and its load aligner.
package lsu_dbus_master_pkg;
   localparam int BE_W = 4;
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_e;
   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;
   // Stores have no unsigned forms, so 100/101 fall back to word like every other undefined code.
   function automatic size_e access_size(input logic [2:0] f3, input logic is_store);
      return (f3 == F3_B || (!is_store && f3 == F3_BU)) ? SZ_B :
             (f3 == F3_H || (!is_store && f3 == F3_HU)) ? SZ_H : SZ_W;
   endfunction
endpackage

// File: rtl/lsu_dbus_master_if.sv
// lsu_dbus_master_if: data-bus request/grant/response signals with master and slave views.
interface lsu_dbus_master_if
   import lsu_dbus_master_pkg::*;
#(parameter int ADDR_WIDTH = 32, parameter int DATA_WIDTH = 32);
   logic                  Dbus_Req;
   logic                  Dbus_We;
   logic [ADDR_WIDTH-1:0] Dbus_Addr;
   logic [DATA_WIDTH-1:0] Dbus_WrtData;
   logic [BE_W-1:0]       Dbus_ByteEn;
   logic                  Dbus_Gnt;
   logic                  Dbus_RdVld;
   logic [DATA_WIDTH-1:0] Dbus_RdData;
   logic                  Dbus_Err;
   modport master (
      output Dbus_Req, Dbus_We, Dbus_Addr, Dbus_WrtData, Dbus_ByteEn,
      input  Dbus_Gnt, Dbus_RdVld, Dbus_RdData, Dbus_Err
   );
   modport slave (
      input  Dbus_Req, Dbus_We, Dbus_Addr, Dbus_WrtData, Dbus_ByteEn,
      output Dbus_Gnt, Dbus_RdVld, Dbus_RdData, Dbus_Err
   );
endinterface

// File: rtl/lsu_load_align.sv
// lsu_load_align: selects the addressed byte/half of a read word and sign/zero-extends it.
module lsu_load_align
   import lsu_dbus_master_pkg::*;
#(parameter int DATA_WIDTH = 32) (
   input  logic [DATA_WIDTH-1:0] rd_data_i,
   input  logic [1:0]            addr_i,
   input  logic [2:0]            funct3_i,
   output logic [DATA_WIDTH-1:0] data_o
);
   logic [7:0]  b;
   logic [15:0] h;
   logic        sgn;
   size_e       sz;
   always_comb begin
      b      = rd_data_i[8*addr_i +: 8];
      h      = rd_data_i[16*addr_i[1] +: 16];
      sgn    = ~funct3_i[2];
      sz     = access_size(funct3_i, 1'b0);
      data_o = sz == SZ_B ? {{(DATA_WIDTH-8){sgn & b[7]}}, b} :
               sz == SZ_H ? {{(DATA_WIDTH-16){sgn & h[15]}}, h} : rd_data_i;
   end
endmodule

// File: rtl/lsu_dbus_master.sv
// lsu_dbus_master: MEM-stage load/store unit driving the data bus and stalling while busy.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of truncating.
module lsu_dbus_master
   import lsu_dbus_master_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ExMem_MemRd_i,
   input  logic                  ExMem_MemWrt_i,
   input  logic [2:0]            ExMem_Funct3_i,
   input  logic [ADDR_WIDTH-1:0] ExMem_Addr_i,
   input  logic [DATA_WIDTH-1:0] ExMem_WrtData_i,
   output logic                  Lsu_Stall_o,
   output logic [DATA_WIDTH-1:0] Lsu_DataRd_o,
   output logic                  Lsu_DataVld_o,
   output logic                  Lsu_BusErr_o,
   lsu_dbus_master_if.master     dbus
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   state_e                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  err_q, err_d, we_q;
   logic [2:0]            f3_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d, ext;
   logic [BE_W-1:0]       be_q, be_d;
   logic                  cmd, misalign, fin, timeout;
   size_e                 sz;
   lsu_load_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
      .rd_data_i (dbus.Dbus_RdData),
      .addr_i    (addr_q[1:0]),
      .funct3_i  (f3_q),
      .data_o    (ext)
   );
   // Command decode and store lane packing; a store wins when both commands are set.
   always_comb begin
      cmd     = ExMem_MemRd_i | ExMem_MemWrt_i;
      sz      = access_size(ExMem_Funct3_i, ExMem_MemWrt_i);
      be_d    = sz == SZ_B ? BE_W'(1) << ExMem_Addr_i[1:0] :
                sz == SZ_H ? BE_W'(3) << {ExMem_Addr_i[1], 1'b0} : '1;
      wdata_d = sz == SZ_B ? {4{ExMem_WrtData_i[7:0]}} :
                sz == SZ_H ? {2{ExMem_WrtData_i[15:0]}} : ExMem_WrtData_i;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign = (sz == SZ_H & ExMem_Addr_i[0]) | (sz == SZ_W & |ExMem_Addr_i[1:0]);
`else
      misalign = 1'b0;
`endif
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   // A real completion in the last allowed cycle takes priority over the timeout.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      rdata_d = rdata_q;
      timeout = cnt_q == CW'(TIMEOUT_CYCLES - 1);
      fin     = state_q == S_REQ ? dbus.Dbus_Gnt & (we_q | dbus.Dbus_Err) :
                (state_q == S_RESP) & dbus.Dbus_RdVld;
      case (state_q)
         S_IDLE: if (cmd) begin
            state_d = misalign ? S_DONE : S_REQ;
            cnt_d   = '0;
            err_d   = misalign;
            rdata_d = misalign ? '0 : rdata_q;
         end
         S_REQ, S_RESP: begin
            cnt_d = cnt_q + 1'b1;
            if (fin | timeout) begin
               state_d = S_DONE;
               err_d   = ~fin | dbus.Dbus_Err;
               rdata_d = (~fin | dbus.Dbus_Err) ? '0 : we_q ? rdata_q : ext;
            end else if (state_q == S_REQ & dbus.Dbus_Gnt) state_d = S_RESP;
         end
         default: state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         cnt_q   <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
         we_q    <= 1'b0;
         f3_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
      end else begin
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
         if (state_q == S_IDLE && cmd) begin
            we_q    <= ExMem_MemWrt_i;
            f3_q    <= ExMem_Funct3_i;
            addr_q  <= ExMem_Addr_i;
            wdata_q <= wdata_d;
            be_q    <= be_d;
         end
      end
   always_comb begin
      dbus.Dbus_Req     = state_q == S_REQ;
      dbus.Dbus_We      = we_q;
      dbus.Dbus_Addr    = {addr_q[ADDR_WIDTH-1:2], 2'b00};
      dbus.Dbus_WrtData = wdata_q;
      dbus.Dbus_ByteEn  = be_q;
      Lsu_Stall_o       = ~rst & (((state_q == S_IDLE) & cmd) | state_q == S_REQ | state_q == S_RESP);
      Lsu_DataVld_o     = state_q == S_DONE;
      Lsu_BusErr_o      = (state_q == S_DONE) & err_q;
      Lsu_DataRd_o      = rdata_q;
   end
endmodule

// File: tb/tb_lsu_dbus_master.sv
// tb_lsu_dbus_master: directed and random load/store transactions against a behavioural model.
module tb_lsu_dbus_master;
   localparam int TMO = 255;
   logic        clk = 1'b0, rst = 1'b1;
   logic        ExMem_MemRd = 1'b0, ExMem_MemWrt = 1'b0;
   logic [2:0]  ExMem_Funct3 = '0;
   logic [31:0] ExMem_Addr = '0, ExMem_WrtData = '0;
   logic        Lsu_Stall, Lsu_DataVld, Lsu_BusErr;
   logic [31:0] Lsu_DataRd;
   logic [31:0] model_rd = '0;
   int          ncmp = 0, nfail = 0;
   lsu_dbus_master_if bus ();
   lsu_dbus_master dut (
      .clk            (clk),
      .rst            (rst),
      .ExMem_MemRd_i  (ExMem_MemRd),
      .ExMem_MemWrt_i (ExMem_MemWrt),
      .ExMem_Funct3_i (ExMem_Funct3),
      .ExMem_Addr_i   (ExMem_Addr),
      .ExMem_WrtData_i(ExMem_WrtData),
      .Lsu_Stall_o    (Lsu_Stall),
      .Lsu_DataRd_o   (Lsu_DataRd),
      .Lsu_DataVld_o  (Lsu_DataVld),
      .Lsu_BusErr_o   (Lsu_BusErr),
      .dbus           (bus)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
      int v;
      case (f3)
         3'd0, 3'd4: begin v = int'((d >> (8 * a[1:0])) & 32'hFF);   if (f3 == 3'd0 && v >= 128)   v -= 256;   end
         3'd1, 3'd5: begin v = int'((d >> (16 * a[1])) & 32'hFFFF);  if (f3 == 3'd1 && v >= 32768) v -= 65536; end
         default:    v = int'(d);
      endcase
      return 32'(v);
   endfunction
   task automatic txn(input string tag, input bit rd, input bit wr, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd, input int gw, input int rw,
                      input logic [31:0] rdat, input bit eg, input bit er);
      bit st, ld, mis, tmo, err, gnt, rdv, in_resp, got;
      int sz, nat, nreq, nstall, nresp;
      logic [31:0] ebe, ewd, edat;
      st  = wr;
      ld  = rd && !wr;
      sz  = st ? (f3 == 3'd0 ? 0 : f3 == 3'd1 ? 1 : 2) :
                 ((f3 == 3'd0 || f3 == 3'd4) ? 0 : (f3 == 3'd1 || f3 == 3'd5) ? 1 : 2);
      mis = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      mis = (sz == 1 && a[0]) || (sz == 2 && a[1:0] != 2'b00);
`endif
      nat  = gw + 1 + ((ld && !eg) ? rw + 1 : 0);
      tmo  = !mis && nat > TMO;
      err  = mis || tmo || eg || (ld && er);
      ebe  = sz == 0 ? 32'd1 << a[1:0] : sz == 1 ? 32'd3 << (2 * a[1]) : 32'd15;
      ewd  = sz == 0 ? (wd & 32'hFF) * 32'h01010101 : sz == 1 ? (wd & 32'hFFFF) * 32'h00010001 : wd;
      edat = err ? 32'd0 : ld ? model_load(f3, a, rdat) : model_rd;
      ExMem_MemRd = rd; ExMem_MemWrt = wr; ExMem_Funct3 = f3; ExMem_Addr = a; ExMem_WrtData = wd;
      nreq = 0; nstall = 0; nresp = 0; in_resp = 1'b0; got = 1'b0;
      for (int c = 0; c < 700 && !got; c++) begin
         gnt = bus.Dbus_Req && nreq == gw;
         rdv = in_resp && nresp == rw;
         bus.Dbus_Gnt    = gnt;
         bus.Dbus_RdVld  = rdv;
         bus.Dbus_Err    = (gnt && eg) || (rdv && er);
         bus.Dbus_RdData = rdv ? rdat : $urandom;
         #4;
         if (Lsu_Stall) nstall++;
         if (bus.Dbus_Req) begin
            nreq++;
            chk({tag, ".addr"}, bus.Dbus_Addr, a & ~32'h3);
            chk({tag, ".we"}, 32'(bus.Dbus_We), 32'(st));
            if (st) begin
               chk({tag, ".be"}, 32'(bus.Dbus_ByteEn), ebe);
               chk({tag, ".wdata"}, bus.Dbus_WrtData, ewd);
            end
         end
         if (in_resp) nresp++;
         if (gnt && ld && !eg) in_resp = 1'b1;
         if (rdv) in_resp = 1'b0;
         if (Lsu_DataVld) begin
            got = 1'b1;
            chk({tag, ".done_stall"}, 32'(Lsu_Stall), 32'd0);
            chk({tag, ".buserr"}, 32'(Lsu_BusErr), 32'(err));
            chk({tag, ".data"}, Lsu_DataRd, edat);
         end
         @(posedge clk); #1;
      end
      chk({tag, ".completed"}, 32'(got), 32'd1);
      chk({tag, ".stall_cycles"}, 32'(nstall), 32'(mis ? 1 : 1 + (nat > TMO ? TMO : nat)));
      chk({tag, ".req_cycles"}, 32'(nreq), 32'(mis ? 0 : (gw + 1 > TMO ? TMO : gw + 1)));
      model_rd = edat;
      ExMem_MemRd = 1'b0; ExMem_MemWrt = 1'b0;
      bus.Dbus_Gnt = 1'b0; bus.Dbus_RdVld = 1'b0; bus.Dbus_Err = 1'b0;
      #4;
      chk({tag, ".one_pulse"}, 32'(Lsu_DataVld), 32'd0);
      chk({tag, ".hold"}, Lsu_DataRd, model_rd);
      @(posedge clk); #1;
   endtask
   initial begin
      bus.Dbus_Gnt = 1'b0; bus.Dbus_RdVld = 1'b0; bus.Dbus_Err = 1'b0; bus.Dbus_RdData = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst.stall", 32'(Lsu_Stall), 32'd0);
      chk("rst.vld", 32'(Lsu_DataVld), 32'd0);
      chk("rst.err", 32'(Lsu_BusErr), 32'd0);
      chk("rst.data", Lsu_DataRd, 32'd0);
      chk("rst.req", 32'(bus.Dbus_Req), 32'd0);
      chk("rst.addr", bus.Dbus_Addr, 32'd0);
      chk("rst.be", 32'(bus.Dbus_ByteEn), 32'd0);
      chk("rst.wdata", bus.Dbus_WrtData, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      txn("lw",     1, 0, 3'd2, 32'h1000, 0, 0, 0, 32'h12345678, 0, 0);
      txn("lb",     1, 0, 3'd0, 32'h1003, 0, 0, 0, 32'h80FF0000, 0, 0);
      txn("lbu",    1, 0, 3'd4, 32'h1003, 0, 0, 0, 32'h80FF0000, 0, 0);
      txn("lhu",    1, 0, 3'd5, 32'h1002, 0, 0, 0, 32'hBEEF1234, 0, 0);
      txn("lh",     1, 0, 3'd1, 32'h1000, 0, 0, 0, 32'h12348001, 0, 0);
      txn("sb",     0, 1, 3'd0, 32'h2001, 32'h000000AB, 0, 0, 0, 0, 0);
      txn("sh",     0, 1, 3'd1, 32'h2002, 32'hCAFE1234, 0, 0, 0, 0, 0);
      txn("sw",     0, 1, 3'd2, 32'h2004, 32'hDEADBEEF, 0, 0, 0, 0, 0);
      txn("both",   1, 1, 3'd0, 32'h2006, 32'h0000005A, 0, 0, 32'hFFFFFFFF, 0, 0);
      txn("gntw3",  1, 0, 3'd2, 32'h1000, 0, 3, 0, 32'hA5A5F00D, 0, 0);
      txn("rdw2",   1, 0, 3'd0, 32'h1001, 0, 0, 2, 32'h0000C300, 0, 0);
      txn("gerr",   1, 0, 3'd2, 32'h1008, 0, 1, 0, 32'h11111111, 1, 0);
      txn("lw2",    1, 0, 3'd2, 32'h1000, 0, 0, 0, 32'h0BADCAFE, 0, 0);
      txn("rerr",   1, 0, 3'd2, 32'h100C, 0, 0, 1, 32'h22222222, 0, 1);
      txn("serr",   0, 1, 3'd2, 32'h3000, 32'h33333333, 2, 0, 0, 1, 0);
      txn("undef3", 1, 0, 3'd3, 32'h1001, 0, 0, 0, 32'h89ABCDEF, 0, 0);
      txn("sundef", 0, 1, 3'd5, 32'h3002, 32'h12345678, 0, 0, 0, 0, 0);
      txn("mis_lw", 1, 0, 3'd2, 32'h1002, 0, 0, 0, 32'h11223344, 0, 0);
      txn("mis_sh", 0, 1, 3'd1, 32'h3001, 32'h0000BEEF, 0, 0, 0, 0, 0);
      txn("edge255",0, 1, 3'd2, 32'h4000, 32'h44444444, TMO - 1, 0, 0, 0, 0);
      txn("tmo_req",1, 0, 3'd2, 32'h4004, 0, 1000, 0, 32'h55555555, 0, 0);
      txn("lw3",    1, 0, 3'd2, 32'h1000, 0, 0, 0, 32'h66666666, 0, 0);
      txn("tmo_rsp",1, 0, 3'd2, 32'h4008, 0, 0, 1000, 32'h77777777, 0, 0);
      // reset while waiting for read data
      ExMem_MemRd = 1'b1; ExMem_Funct3 = 3'd2; ExMem_Addr = 32'h1000;
      @(posedge clk); #1;
      chk("rstresp.req_on", 32'(bus.Dbus_Req), 32'd1);
      bus.Dbus_Gnt = 1'b1;
      @(posedge clk); #1;
      bus.Dbus_Gnt = 1'b0;
      chk("rstresp.stall_on", 32'(Lsu_Stall), 32'd1);
      rst = 1'b1;
      #1;
      chk("rstresp.stall", 32'(Lsu_Stall), 32'd0);
      chk("rstresp.req", 32'(bus.Dbus_Req), 32'd0);
      chk("rstresp.vld", 32'(Lsu_DataVld), 32'd0);
      @(posedge clk); #1;
      ExMem_MemRd = 1'b0;
      rst = 1'b0;
      #4;
      chk("rstresp.vld2", 32'(Lsu_DataVld), 32'd0);
      chk("rstresp.data", Lsu_DataRd, 32'd0);
      model_rd = '0;
      @(posedge clk); #1;
      txn("after_rst", 1, 0, 3'd2, 32'h1000, 0, 0, 0, 32'h0F1E2D3C, 0, 0);
      // reset while requesting the bus
      ExMem_MemWrt = 1'b1; ExMem_Funct3 = 3'd2; ExMem_Addr = 32'h5000;
      @(posedge clk); #1;
      chk("rstreq.req_on", 32'(bus.Dbus_Req), 32'd1);
      rst = 1'b1;
      #1;
      chk("rstreq.req", 32'(bus.Dbus_Req), 32'd0);
      @(posedge clk); #1;
      ExMem_MemWrt = 1'b0;
      rst = 1'b0;
      model_rd = '0;
      @(posedge clk); #1;
      for (int i = 0; i < 40; i++) begin
         int k;
         k = $urandom_range(0, 3);
         txn($sformatf("rnd%0d", i), k != 1, k >= 1, 3'($urandom_range(0, 7)), $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom,
             $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end
endmodule
